// File: rtl/psk_fir_pkg.sv
// Shared definitions for the PSK pulse-shaping FIR path: loader state encoding
// and a ceil-log2 helper for sizing index buses in parameterised blocks.
package psk_fir_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_ARMED = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_LOAD  = ST_LOAD,
    S_ARMED = ST_ARMED
  } load_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/coeff_bank.sv
// Shadow/active coefficient storage: indexed shadow write, single-edge copy of the
// whole shadow bank into the active bank, which drives the flat output bus directly.
module coeff_bank #(
  parameter int COEFF_W     = 16,
  parameter int FILTER_TAPS = 4,
  parameter int IDX_W       = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_wr_en,
  input  logic [IDX_W-1:0]               i_wr_idx,
  input  logic [COEFF_W-1:0]             i_wr_dat,
  input  logic                           i_commit,
  output logic [FILTER_TAPS*COEFF_W-1:0] o_active
);

  logic [COEFF_W-1:0]             r_shadow [FILTER_TAPS];
  logic [FILTER_TAPS*COEFF_W-1:0] r_active;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < FILTER_TAPS; i++) r_shadow[i] <= '0;
    end else if (i_wr_en) begin
      for (int i = 0; i < FILTER_TAPS; i++)
        if (i_wr_idx == IDX_W'(i)) r_shadow[i] <= i_wr_dat;
    end
  end

  // Never written in the same cycle as the shadow: commit only happens from ARMED.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_active <= '0;
    end else if (i_commit) begin
      for (int i = 0; i < FILTER_TAPS; i++)
        r_active[i*COEFF_W +: COEFF_W] <= r_shadow[i];
    end
  end

  assign o_active = r_active;

endmodule

// File: rtl/fir_coeff_loader.sv
// Streams FIR taps into a shadow bank and commits them atomically on a sample_en boundary.
// Optional registered tap readback port when FIR_COEFF_READBACK_EN is defined.
module fir_coeff_loader
  import psk_fir_pkg::*;
#(
  parameter  int COEFF_W     = 16,
  parameter  int FILTER_TAPS = 4,
  localparam int IDX_W       = (clog2(FILTER_TAPS) < 1) ? 1 : clog2(FILTER_TAPS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_start,
  input  logic [COEFF_W-1:0]             cfg_data,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic                           sample_en,
  output logic [FILTER_TAPS*COEFF_W-1:0] coeff_vector,
  output logic                           busy,
  output logic                           load_done,
  output logic                           load_abort
`ifdef FIR_COEFF_READBACK_EN
  ,
  input  logic [IDX_W-1:0]               rd_addr,
  output logic [COEFF_W-1:0]             rd_data
`endif
);

  load_state_t      r_state;
  load_state_t      w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic             r_done;
  logic             r_abort;
  logic             w_accept;
  logic             w_commit;
  logic             w_restart;
  logic             w_last;

  assign w_last = (r_idx == IDX_W'(FILTER_TAPS - 1));

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // A restart outranks both a word handshake and a commit in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    w_restart   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (cfg_start) begin
          w_restart = 1'b1;
        end else if (cfg_valid) begin
          w_accept = 1'b1;
          if (w_last) w_state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (cfg_start) begin
          w_restart   = 1'b1;
          w_state_nxt = S_LOAD;
        end else if (sample_en) begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idx   <= '0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (cfg_start)     r_idx <= '0;
      else if (w_accept) r_idx <= w_last ? '0 : r_idx + 1'b1;
      if (w_restart)     r_abort <= 1'b1;
      else if (w_commit) r_abort <= 1'b0;
    end
  end

  coeff_bank #(
    .COEFF_W     (COEFF_W),
    .FILTER_TAPS (FILTER_TAPS),
    .IDX_W       (IDX_W)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .i_wr_en  (w_accept),
    .i_wr_idx (r_idx),
    .i_wr_dat (cfg_data),
    .i_commit (w_commit),
    .o_active (coeff_vector)
  );

  assign cfg_ready  = (r_state == S_LOAD);
  assign busy       = (r_state != S_IDLE);
  assign load_done  = r_done;
  assign load_abort = r_abort;

`ifdef FIR_COEFF_READBACK_EN
  logic [COEFF_W-1:0] w_rd_mux;
  logic [COEFF_W-1:0] r_rd_data;

  // Addresses past the last tap match no entry and read back as zero.
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < FILTER_TAPS; i++)
      if (rd_addr == IDX_W'(i)) w_rd_mux = coeff_vector[i*COEFF_W +: COEFF_W];
  end

  always_ff @(posedge clk) begin
    if (!rst) r_rd_data <= '0;
    else      r_rd_data <= w_rd_mux;
  end

  assign rd_data = r_rd_data;
`endif

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed table-driven bench for fir_coeff_loader (FILTER_TAPS=4, COEFF_W=16).
module tb_fir_coeff_loader;

  localparam logic [63:0] V1  = 64'h0004_0003_0002_0001;
  localparam logic [63:0] V2  = 64'h0044_0033_0022_0011;
  localparam logic [63:0] V3  = 64'h0040_0030_0020_0010;
  localparam logic [63:0] VAA = 64'h00AA_00AA_00AA_00AA;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_start = 1'b0;
  logic [15:0] cfg_data = '0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic        sample_en = 1'b0;
  logic [63:0] coeff_vector;
  logic        busy;
  logic        load_done;
  logic        load_abort;
`ifdef FIR_COEFF_READBACK_EN
  logic [1:0]  rd_addr = '0;
  logic [15:0] rd_data;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fir_coeff_loader #(.COEFF_W(16), .FILTER_TAPS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_data     (cfg_data),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .sample_en    (sample_en),
    .coeff_vector (coeff_vector),
    .busy         (busy),
    .load_done    (load_done),
    .load_abort   (load_abort)
`ifdef FIR_COEFF_READBACK_EN
    ,
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
`endif
  );

  typedef struct {
    logic        start;
    logic        valid;
    logic [15:0] data;
    logic        se;
    logic        e_ready;
    logic        e_busy;
    logic        e_done;
    logic        e_abort;
    logic [63:0] e_vec;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic s, input logic v, input logic [15:0] d, input logic se,
                              input logic rdy, input logic bsy, input logic dn, input logic ab,
                              input logic [63:0] vec);
    vec_t e;
    e.start = s; e.valid = v; e.data = d; e.se = se;
    e.e_ready = rdy; e.e_busy = bsy; e.e_done = dn; e.e_abort = ab; e.e_vec = vec;
    tbl.push_back(e);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the edge that consumed them.
  task automatic step(input logic s, input logic v, input logic [15:0] d, input logic se);
    cfg_start = s; cfg_valid = v; cfg_data = d; sample_en = se;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    // Single load then commit
    add(1, 0, 16'h0000, 0,  1, 1, 0, 0, 64'h0);
    add(0, 1, 16'h0001, 0,  1, 1, 0, 0, 64'h0);
    add(0, 1, 16'h0002, 0,  1, 1, 0, 0, 64'h0);
    add(0, 1, 16'h0003, 0,  1, 1, 0, 0, 64'h0);
    add(0, 1, 16'h0004, 0,  0, 1, 0, 0, 64'h0);
    add(0, 0, 16'h0000, 1,  0, 0, 1, 0, V1);
    add(0, 0, 16'h0000, 0,  0, 0, 0, 0, V1);
    // Commit gating: armed for 10 cycles without sample_en
    add(1, 0, 16'h0000, 0,  1, 1, 0, 0, V1);
    add(0, 1, 16'h0011, 0,  1, 1, 0, 0, V1);
    add(0, 1, 16'h0022, 0,  1, 1, 0, 0, V1);
    add(0, 1, 16'h0033, 0,  1, 1, 0, 0, V1);
    add(0, 1, 16'h0044, 0,  0, 1, 0, 0, V1);
    for (int k = 0; k < 10; k++) add(0, 0, 16'h0000, 0,  0, 1, 0, 0, V1);
    add(0, 0, 16'h0000, 1,  0, 0, 1, 0, V2);
    add(0, 0, 16'h0000, 0,  0, 0, 0, 0, V2);
    // Gapped valid; stray valid/sample_en in IDLE, LOAD and ARMED must be ignored
    add(0, 1, 16'hDEAD, 1,  0, 0, 0, 0, V2);
    add(1, 1, 16'hDEAD, 0,  1, 1, 0, 0, V2);
    add(0, 1, 16'h0010, 0,  1, 1, 0, 0, V2);
    add(0, 0, 16'h5555, 1,  1, 1, 0, 0, V2);
    add(0, 1, 16'h0020, 0,  1, 1, 0, 0, V2);
    add(0, 0, 16'h6666, 0,  1, 1, 0, 0, V2);
    add(0, 1, 16'h0030, 0,  1, 1, 0, 0, V2);
    add(0, 0, 16'h7777, 0,  1, 1, 0, 0, V2);
    add(0, 1, 16'h0040, 0,  0, 1, 0, 0, V2);
    add(0, 1, 16'hBEEF, 0,  0, 1, 0, 0, V2);
    add(0, 0, 16'h0000, 1,  0, 0, 1, 0, V3);
    add(0, 0, 16'h0000, 0,  0, 0, 0, 0, V3);

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst vec",   coeff_vector, 64'h0);
    chk("rst ready", 64'(cfg_ready), 64'h0);
    chk("rst busy",  64'(busy), 64'h0);
    chk("rst done",  64'(load_done), 64'h0);
    chk("rst abort", 64'(load_abort), 64'h0);
`ifdef FIR_COEFF_READBACK_EN
    chk("rst rd_data", 64'(rd_data), 64'h0);
`endif
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].start, tbl[i].valid, tbl[i].data, tbl[i].se);
      chk($sformatf("row%0d ready", i), 64'(cfg_ready),  64'(tbl[i].e_ready));
      chk($sformatf("row%0d busy",  i), 64'(busy),       64'(tbl[i].e_busy));
      chk($sformatf("row%0d done",  i), 64'(load_done),  64'(tbl[i].e_done));
      chk($sformatf("row%0d abort", i), 64'(load_abort), 64'(tbl[i].e_abort));
      chk($sformatf("row%0d vec",   i), coeff_vector,    tbl[i].e_vec);
`ifdef FIR_COEFF_READBACK_EN
      if (i == 6) begin
        rd_addr = 2'd2;
        step(0, 0, 16'h0, 0);
        chk("readback tap2", 64'(rd_data), 64'h0003);
        rd_addr = 2'd0;
        step(0, 0, 16'h0, 0);
        chk("readback tap0", 64'(rd_data), 64'h0001);
        rd_addr = 2'd3;
        step(0, 0, 16'h0, 0);
        chk("readback tap3", 64'(rd_data), 64'h0004);
      end
`endif
    end

    // Restart mid-load: partial words and the word coincident with restart are discarded
    step(1, 0, 16'h0000, 0);
    step(0, 1, 16'h0101, 0);
    step(0, 1, 16'h0202, 0);
    chk("pre-restart abort", 64'(load_abort), 64'h0);
    step(1, 1, 16'h0BAD, 0);
    chk("restart abort", 64'(load_abort), 64'h1);
    chk("restart ready", 64'(cfg_ready), 64'h1);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 16'h00AA, 0);
      chk($sformatf("restart w%0d abort", k), 64'(load_abort), 64'h1);
    end
    chk("restart armed ready", 64'(cfg_ready), 64'h0);
    chk("restart armed vec", coeff_vector, V3);
    step(0, 0, 16'h0000, 1);
    chk("restart commit done", 64'(load_done), 64'h1);
    chk("restart commit vec", coeff_vector, VAA);
    step(0, 0, 16'h0000, 0);
    chk("restart post abort", 64'(load_abort), 64'h0);
    chk("restart post done", 64'(load_done), 64'h0);

    // Restart from ARMED
    step(1, 0, 16'h0000, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 16'h0123, 0);
    chk("armed2 ready", 64'(cfg_ready), 64'h0);
    step(1, 0, 16'h0000, 0);
    chk("armed restart abort", 64'(load_abort), 64'h1);
    chk("armed restart ready", 64'(cfg_ready), 64'h1);
    chk("armed restart vec", coeff_vector, VAA);

    // Reset mid-load
    step(1, 0, 16'h0000, 0);
    for (int k = 0; k < 3; k++) step(0, 1, 16'h0777, 0);
    rst = 1'b0;
    step(0, 0, 16'h0000, 0);
    chk("midrst vec",   coeff_vector, 64'h0);
    chk("midrst ready", 64'(cfg_ready), 64'h0);
    chk("midrst busy",  64'(busy), 64'h0);
    chk("midrst abort", 64'(load_abort), 64'h0);
    rst = 1'b1;
    step(0, 1, 16'h0999, 1);
    chk("postrst ready", 64'(cfg_ready), 64'h0);
    chk("postrst vec", coeff_vector, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
